// File: rtl/vx_fill_assembler_pkg.sv
// Shared fill-path definitions: beat geometry helpers, default widths and the
// fill request bundle consumed by the bank's fill mux.
package vx_fill_assembler_pkg;

  localparam int DEFAULT_CACHE_LINE_SIZE = 64;
  localparam int DEFAULT_MEM_DATA_WIDTH  = 128;
  localparam int DEFAULT_LINE_ADDR_WIDTH = 26;
  localparam int DEFAULT_TAG_WIDTH       = 8;

  function automatic int fill_beats(input int line_size, input int mem_width);
    return (line_size * 8) / mem_width;
  endfunction

  // Beat-select width never collapses to zero, even for single-beat lines.
  function automatic int beat_sel_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int DEFAULT_BEATS = fill_beats(DEFAULT_CACHE_LINE_SIZE, DEFAULT_MEM_DATA_WIDTH);
  localparam int DEFAULT_BEAT_SEL_WIDTH = beat_sel_width(DEFAULT_BEATS);

  typedef struct packed {
    logic [DEFAULT_LINE_ADDR_WIDTH-1:0]   addr;
    logic [DEFAULT_TAG_WIDTH-1:0]         tag;
    logic [DEFAULT_CACHE_LINE_SIZE*8-1:0] data;
  } fill_req_t;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } fill_state_e;

endpackage

// File: rtl/vx_fill_assembler_if.sv
// Memory-response beat stream in, assembled fill request out.
interface vx_fill_assembler_if #(
  parameter int CACHE_LINE_SIZE = vx_fill_assembler_pkg::DEFAULT_CACHE_LINE_SIZE,
  parameter int MEM_DATA_WIDTH  = vx_fill_assembler_pkg::DEFAULT_MEM_DATA_WIDTH,
  parameter int LINE_ADDR_WIDTH = vx_fill_assembler_pkg::DEFAULT_LINE_ADDR_WIDTH,
  parameter int TAG_WIDTH       = vx_fill_assembler_pkg::DEFAULT_TAG_WIDTH
);
  logic                         mem_rsp_valid;
  logic                         mem_rsp_ready;
  logic [MEM_DATA_WIDTH-1:0]    mem_rsp_data;
  logic [LINE_ADDR_WIDTH-1:0]   mem_rsp_addr;
  logic [TAG_WIDTH-1:0]         mem_rsp_tag;
  logic                         mem_rsp_last;
  logic                         fill_valid;
  logic                         fill_ready;
  logic [LINE_ADDR_WIDTH-1:0]   fill_addr;
  logic [TAG_WIDTH-1:0]         fill_tag;
  logic [CACHE_LINE_SIZE*8-1:0] fill_data;
  logic                         protocol_err;

  modport master (
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_addr, mem_rsp_tag, mem_rsp_last, fill_ready,
    output mem_rsp_ready, fill_valid, fill_addr, fill_tag, fill_data, protocol_err
  );

  modport slave (
    output mem_rsp_valid, mem_rsp_data, mem_rsp_addr, mem_rsp_tag, mem_rsp_last, fill_ready,
    input  mem_rsp_ready, fill_valid, fill_addr, fill_tag, fill_data, protocol_err
  );
endinterface

// File: rtl/vx_fill_beat_ctr.sv
// Beat index within the current line, wrap detection and sticky end-of-line
// marker mismatch flag.
module vx_fill_beat_ctr
  import vx_fill_assembler_pkg::*;
#(
  parameter int BEATS = DEFAULT_BEATS,
  parameter int SEL_W = beat_sel_width(BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             last,
  output logic [SEL_W-1:0] idx,
  output logic             wrap,
  output logic             err
);
  logic is_final;

  assign is_final = (idx == SEL_W'(BEATS - 1));
  assign wrap     = accept && is_final;

  // The line always completes by count; the source's marker is only audited.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      err <= 1'b0;
    end else if (accept) begin
      idx <= wrap ? '0 : idx + 1'b1;
      if (last != is_final) err <= 1'b1;
    end
  end
endmodule

// File: rtl/vx_fill_assembler.sv
// Gathers memory-response beats into one cache line and presents it as a
// single fill request to the data store.
module vx_fill_assembler
  import vx_fill_assembler_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = DEFAULT_CACHE_LINE_SIZE,
  parameter int MEM_DATA_WIDTH  = DEFAULT_MEM_DATA_WIDTH,
  parameter int LINE_ADDR_WIDTH = DEFAULT_LINE_ADDR_WIDTH,
  parameter int TAG_WIDTH       = DEFAULT_TAG_WIDTH
) (
  input logic               clk,
  input logic               reset,
  vx_fill_assembler_if.master bus
);
  localparam int unsigned BEATS  = unsigned'(fill_beats(CACHE_LINE_SIZE, MEM_DATA_WIDTH));
  localparam int          SEL_W  = beat_sel_width(BEATS);
  localparam int          LINE_W = CACHE_LINE_SIZE * 8;

  fill_state_e                state;
  logic                       valid_q;
  logic                       accept;
  logic                       wrap;
  logic                       beat_err;
  logic [SEL_W-1:0]           idx;
  logic [LINE_W-1:0]          data_q;
  logic [LINE_ADDR_WIDTH-1:0] addr_q;
  logic [TAG_WIDTH-1:0]       tag_q;

  // While a line is held, a new beat may only enter alongside the fill handshake.
  assign bus.mem_rsp_ready = (state == COLLECT) ? 1'b1 : bus.fill_ready;
  assign accept            = bus.mem_rsp_valid && bus.mem_rsp_ready;

  vx_fill_beat_ctr #(
    .BEATS (BEATS),
    .SEL_W (SEL_W)
  ) u_beat_ctr (
    .clk    (clk),
    .rst    (reset),
    .accept (accept),
    .last   (bus.mem_rsp_last),
    .idx    (idx),
    .wrap   (wrap),
    .err    (beat_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= COLLECT;
      valid_q <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (wrap) begin
            state   <= PRESENT;
            valid_q <= 1'b1;
          end
        end
        PRESENT: begin
          // A wrap here means a single-beat line refilled in the handshake cycle.
          if (bus.fill_ready && !wrap) begin
            state   <= COLLECT;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= COLLECT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (idx == SEL_W'(b)) data_q[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= bus.mem_rsp_data;
      end
      if (idx == '0) begin
        addr_q <= bus.mem_rsp_addr;
        tag_q  <= bus.mem_rsp_tag;
      end
    end
  end

  assign bus.fill_valid   = valid_q;
  assign bus.fill_data    = data_q;
  assign bus.fill_addr    = addr_q;
  assign bus.fill_tag     = tag_q;
  assign bus.protocol_err = beat_err;
endmodule

// File: tb/tb_vx_fill_assembler.sv
// Bench for vx_fill_assembler: a 4-beat instance and a single-beat instance,
// each compared cycle by cycle against a line-level reference model.
module tb_vx_fill_assembler;
  localparam int LS = 64;
  localparam int MW = 128;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int LW = LS * 8;
  localparam int NB = LW / MW;

  typedef struct {
    bit            v;
    logic [MW-1:0] d;
    logic [AW-1:0] a;
    logic [TW-1:0] t;
    bit            l;
    bit            fr;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vx_fill_assembler_if #(.CACHE_LINE_SIZE(LS), .MEM_DATA_WIDTH(MW), .LINE_ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus_a ();
  vx_fill_assembler_if #(.CACHE_LINE_SIZE(LS), .MEM_DATA_WIDTH(LW), .LINE_ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus_b ();

  vx_fill_assembler #(.CACHE_LINE_SIZE(LS), .MEM_DATA_WIDTH(MW), .LINE_ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a));
  vx_fill_assembler #(.CACHE_LINE_SIZE(LS), .MEM_DATA_WIDTH(LW), .LINE_ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b));

  int nchk = 0;
  int nfail = 0;

  // Reference model: a line is whatever the last NB accepted beats were, in order.
  logic [MW-1:0] m_beats[$];
  logic [AW-1:0] m_paddr;
  logic [TW-1:0] m_ptag;
  bit            m_pv;
  logic [LW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic [TW-1:0] m_tag;
  bit            m_err;
  bit            b_pv;
  logic [LW-1:0] b_data;
  logic [AW-1:0] b_addr;
  logic [TW-1:0] b_tag;

  function automatic logic [MW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] rnd512();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic stim_t mk(input bit v, input logic [MW-1:0] d, input logic [AW-1:0] a,
                               input logic [TW-1:0] t, input bit l, input bit fr);
    stim_t s;
    s.v = v; s.d = d; s.a = a; s.t = t; s.l = l; s.fr = fr;
    return s;
  endfunction

  task automatic model_clear();
    m_beats.delete();
    m_pv  = 1'b0;
    m_err = 1'b0;
    b_pv  = 1'b0;
  endtask

  task automatic model_tick();
    bit fr, acc;
    if (rst) begin
      model_clear();
      return;
    end
    fr  = bus_a.fill_ready;
    acc = bus_a.mem_rsp_valid && (!m_pv || fr);
    if (m_pv && fr) m_pv = 1'b0;
    if (acc) begin
      if (m_beats.size() == 0) begin
        m_paddr = bus_a.mem_rsp_addr;
        m_ptag  = bus_a.mem_rsp_tag;
      end
      if (bus_a.mem_rsp_last != (m_beats.size() == NB - 1)) m_err = 1'b1;
      m_beats.push_back(bus_a.mem_rsp_data);
      if (m_beats.size() == NB) begin
        for (int i = 0; i < NB; i++) m_data[i*MW +: MW] = m_beats[i];
        m_addr = m_paddr;
        m_tag  = m_ptag;
        m_pv   = 1'b1;
        m_beats.delete();
      end
    end
    fr  = bus_b.fill_ready;
    acc = bus_b.mem_rsp_valid && (!b_pv || fr);
    if (b_pv && fr) b_pv = 1'b0;
    if (acc) begin
      b_pv   = 1'b1;
      b_data = bus_b.mem_rsp_data;
      b_addr = bus_b.mem_rsp_addr;
      b_tag  = bus_b.mem_rsp_tag;
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input stim_t s);
    bus_a.mem_rsp_valid = s.v;
    bus_a.mem_rsp_data  = s.d;
    bus_a.mem_rsp_addr  = s.a;
    bus_a.mem_rsp_tag   = s.t;
    bus_a.mem_rsp_last  = s.l;
    bus_a.fill_ready    = s.fr;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    nchk++;
    if (bus_a.fill_valid !== 1'b0) begin nfail++; $display("FAIL reset fill_valid: got %b want 0", bus_a.fill_valid); end
    nchk++;
    if (bus_a.mem_rsp_ready !== 1'b1) begin nfail++; $display("FAIL reset mem_rsp_ready: got %b want 1", bus_a.mem_rsp_ready); end
    nchk++;
    if (bus_a.protocol_err !== 1'b0) begin nfail++; $display("FAIL reset protocol_err: got %b want 0", bus_a.protocol_err); end
    nchk++;
    if (bus_b.fill_valid !== 1'b0) begin nfail++; $display("FAIL reset b fill_valid: got %b want 0", bus_b.fill_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_assembly();
    logic [7:0] bt;
    for (int k = 0; k < NB; k++) begin
      bt = 8'(17 * (k + 1));
      drive_a(mk(1, {16{bt}}, 26'h123, 8'd5, k == NB - 1, 1));
      nchk++;
      if (bus_a.fill_valid !== 1'b0) begin nfail++; $display("FAIL assembly early fill_valid beat %0d: got %b want 0", k, bus_a.fill_valid); end
      nchk++;
      if (bus_a.mem_rsp_ready !== 1'b1) begin nfail++; $display("FAIL assembly ready beat %0d: got %b want 1", k, bus_a.mem_rsp_ready); end
      tick();
    end
    drive_a(mk(0, '0, '0, '0, 0, 1));
    nchk++;
    if (bus_a.fill_valid !== 1'b1) begin nfail++; $display("FAIL assembly fill_valid: got %b want 1", bus_a.fill_valid); end
    nchk++;
    if (bus_a.fill_data !== {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}}) begin
      nfail++; $display("FAIL assembly fill_data: got %h", bus_a.fill_data);
    end
    nchk++;
    if (bus_a.fill_addr !== 26'h123 || bus_a.fill_tag !== 8'd5) begin
      nfail++; $display("FAIL assembly addr/tag: got %h/%h want 123/05", bus_a.fill_addr, bus_a.fill_tag);
    end
    nchk++;
    if (bus_a.protocol_err !== 1'b0) begin nfail++; $display("FAIL assembly protocol_err: got %b want 0", bus_a.protocol_err); end
    tick();
    drive_a(mk(0, '0, '0, '0, 0, 1));
    nchk++;
    if (bus_a.fill_valid !== 1'b0) begin nfail++; $display("FAIL assembly after handshake fill_valid: got %b want 0", bus_a.fill_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    stim_t s[$];
    logic [MW-1:0] nxt;
    bit exp_rdy;
    nxt = rnd128();
    for (int k = 0; k < NB; k++) s.push_back(mk(1, rnd128(), 26'h2A5, 8'd7, k == NB - 1, 0));
    for (int k = 0; k < 5; k++) s.push_back(mk(1, nxt, 26'h3B1, 8'd9, 0, 0));
    s.push_back(mk(1, nxt, 26'h3B1, 8'd9, 0, 1));
    for (int k = 1; k < NB; k++) s.push_back(mk(1, rnd128(), 26'h0, 8'd0, k == NB - 1, 1));
    s.push_back(mk(0, '0, '0, '0, 0, 1));
    s.push_back(mk(0, '0, '0, '0, 0, 1));
    foreach (s[i]) begin
      drive_a(s[i]);
      exp_rdy = !m_pv || s[i].fr;
      nchk++;
      if (bus_a.mem_rsp_ready !== exp_rdy) begin nfail++; $display("FAIL backpressure ready @%0d: got %b want %b", i, bus_a.mem_rsp_ready, exp_rdy); end
      nchk++;
      if (bus_a.fill_valid !== m_pv) begin nfail++; $display("FAIL backpressure fill_valid @%0d: got %b want %b", i, bus_a.fill_valid, m_pv); end
      if (m_pv) begin
        nchk++;
        if ({bus_a.fill_addr, bus_a.fill_tag, bus_a.fill_data} !== {m_addr, m_tag, m_data}) begin
          nfail++; $display("FAIL backpressure line @%0d: got %h/%h/%h want %h/%h/%h", i,
                            bus_a.fill_addr, bus_a.fill_tag, bus_a.fill_data, m_addr, m_tag, m_data);
        end
      end
      nchk++;
      if (bus_a.protocol_err !== m_err) begin nfail++; $display("FAIL backpressure protocol_err @%0d: got %b want %b", i, bus_a.protocol_err, m_err); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    logic [TW-1:0] obs[$];
    for (int k = 0; k < 2 * NB; k++)
      s.push_back(mk(1, rnd128(), (k < NB) ? 26'h0A1 : 26'h0B2, (k < NB) ? 8'd5 : 8'd6, (k % NB) == NB - 1, 1));
    s.push_back(mk(0, '0, '0, '0, 0, 1));
    s.push_back(mk(0, '0, '0, '0, 0, 1));
    foreach (s[i]) begin
      drive_a(s[i]);
      nchk++;
      if (bus_a.mem_rsp_ready !== 1'b1) begin nfail++; $display("FAIL b2b ready bubble @%0d: got %b want 1", i, bus_a.mem_rsp_ready); end
      nchk++;
      if (bus_a.fill_valid !== m_pv) begin nfail++; $display("FAIL b2b fill_valid @%0d: got %b want %b", i, bus_a.fill_valid, m_pv); end
      if (m_pv) begin
        nchk++;
        if ({bus_a.fill_addr, bus_a.fill_tag, bus_a.fill_data} !== {m_addr, m_tag, m_data}) begin
          nfail++; $display("FAIL b2b line @%0d: got %h/%h/%h want %h/%h/%h", i,
                            bus_a.fill_addr, bus_a.fill_tag, bus_a.fill_data, m_addr, m_tag, m_data);
        end
      end
      if (i == NB) begin
        nchk++;
        if (bus_a.fill_valid !== 1'b1) begin nfail++; $display("FAIL b2b overlap: fill_valid got %b want 1 with beat %0d", bus_a.fill_valid, NB); end
      end
      if (bus_a.fill_valid === 1'b1 && bus_a.fill_ready === 1'b1) obs.push_back(bus_a.fill_tag);
      tick();
    end
    nchk++;
    if (obs.size() != 2) begin
      nfail++; $display("FAIL b2b fill count: got %0d want 2", obs.size());
    end else begin
      nchk++;
      if (obs[0] !== 8'd5 || obs[1] !== 8'd6) begin nfail++; $display("FAIL b2b tags: got %0d,%0d want 5,6", obs[0], obs[1]); end
    end
  endtask

  task automatic test_protocol_err();
    stim_t s[$];
    apply_reset();
    for (int k = 0; k < NB; k++) s.push_back(mk(1, rnd128(), 26'h155, 8'd3, (k == 1) || (k == NB - 1), 1));
    for (int k = 0; k < NB; k++) s.push_back(mk(1, rnd128(), 26'h156, 8'd4, k == NB - 1, 1));
    s.push_back(mk(0, '0, '0, '0, 0, 1));
    s.push_back(mk(0, '0, '0, '0, 0, 1));
    foreach (s[i]) begin
      drive_a(s[i]);
      nchk++;
      if (bus_a.fill_valid !== m_pv) begin nfail++; $display("FAIL proto fill_valid @%0d: got %b want %b", i, bus_a.fill_valid, m_pv); end
      if (m_pv) begin
        nchk++;
        if ({bus_a.fill_addr, bus_a.fill_tag, bus_a.fill_data} !== {m_addr, m_tag, m_data}) begin
          nfail++; $display("FAIL proto line @%0d: got %h/%h/%h want %h/%h/%h", i,
                            bus_a.fill_addr, bus_a.fill_tag, bus_a.fill_data, m_addr, m_tag, m_data);
        end
      end
      nchk++;
      if (bus_a.protocol_err !== m_err) begin nfail++; $display("FAIL proto protocol_err @%0d: got %b want %b", i, bus_a.protocol_err, m_err); end
      if (i >= 2) begin
        nchk++;
        if (bus_a.protocol_err !== 1'b1) begin nfail++; $display("FAIL proto sticky @%0d: got %b want 1", i, bus_a.protocol_err); end
      end
      tick();
    end
    apply_reset();
    for (int k = 0; k < NB; k++) begin
      drive_a(mk(1, rnd128(), 26'h157, 8'd2, 0, 1));
      nchk++;
      if (bus_a.protocol_err !== 1'b0) begin nfail++; $display("FAIL proto missing-last early beat %0d: got %b want 0", k, bus_a.protocol_err); end
      tick();
    end
    drive_a(mk(0, '0, '0, '0, 0, 1));
    nchk++;
    if (bus_a.protocol_err !== 1'b1) begin nfail++; $display("FAIL proto missing-last: got %b want 1", bus_a.protocol_err); end
    nchk++;
    if (bus_a.fill_valid !== 1'b1) begin nfail++; $display("FAIL proto missing-last fill_valid: got %b want 1", bus_a.fill_valid); end
    tick();
  endtask

  task automatic test_reset_midline();
    logic [MW-1:0] bd[NB];
    logic [LW-1:0] exp_line;
    logic [LW-1:0] obs[$];
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive_a(mk(1, rnd128(), 26'hAAA, 8'd1, 0, 1));
      tick();
    end
    rst = 1'b1;
    model_clear();
    #1;
    nchk++;
    if (bus_a.fill_valid !== 1'b0 || bus_a.protocol_err !== 1'b0) begin
      nfail++; $display("FAIL midline reset: fill_valid/err got %b/%b want 0/0", bus_a.fill_valid, bus_a.protocol_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NB; k++) begin
      bd[k] = rnd128();
      exp_line[k*MW +: MW] = bd[k];
    end
    for (int k = 0; k < NB + 3; k++) begin
      if (k < NB) drive_a(mk(1, bd[k], 26'hBBB, 8'd2, k == NB - 1, 1));
      else drive_a(mk(0, '0, '0, '0, 0, 1));
      if (bus_a.fill_valid === 1'b1) begin
        obs.push_back(bus_a.fill_data);
        nchk++;
        if (bus_a.fill_addr !== 26'hBBB) begin nfail++; $display("FAIL midline addr: got %h want bbb", bus_a.fill_addr); end
      end
      tick();
    end
    nchk++;
    if (obs.size() != 1) begin
      nfail++; $display("FAIL midline fill count: got %0d want 1", obs.size());
    end else begin
      nchk++;
      if (obs[0] !== exp_line) begin nfail++; $display("FAIL midline data: got %h want %h", obs[0], exp_line); end
    end
    // Pending fill must vanish the moment reset asserts, without a clock edge.
    for (int k = 0; k < NB; k++) begin
      drive_a(mk(1, rnd128(), 26'hCCC, 8'd3, k == NB - 1, 0));
      tick();
    end
    drive_a(mk(0, '0, '0, '0, 0, 0));
    nchk++;
    if (bus_a.fill_valid !== 1'b1) begin nfail++; $display("FAIL pending before reset: got %b want 1", bus_a.fill_valid); end
    rst = 1'b1;
    model_clear();
    #1;
    nchk++;
    if (bus_a.fill_valid !== 1'b0) begin nfail++; $display("FAIL pending discard: fill_valid got %b want 0", bus_a.fill_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    stim_t st;
    bit exp_rdy;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      st = mk($urandom_range(0, 3) != 0, rnd128(), AW'($urandom), TW'($urandom),
              (m_beats.size() == NB - 1) ^ ($urandom_range(0, 15) == 0), $urandom_range(0, 3) != 0);
      drive_a(st);
      exp_rdy = !m_pv || st.fr;
      nchk++;
      if (bus_a.mem_rsp_ready !== exp_rdy) begin nfail++; $display("FAIL random ready @%0d: got %b want %b", i, bus_a.mem_rsp_ready, exp_rdy); end
      nchk++;
      if (bus_a.fill_valid !== m_pv) begin nfail++; $display("FAIL random fill_valid @%0d: got %b want %b", i, bus_a.fill_valid, m_pv); end
      if (m_pv) begin
        nchk++;
        if ({bus_a.fill_addr, bus_a.fill_tag, bus_a.fill_data} !== {m_addr, m_tag, m_data}) begin
          nfail++; $display("FAIL random line @%0d: got %h/%h/%h want %h/%h/%h", i,
                            bus_a.fill_addr, bus_a.fill_tag, bus_a.fill_data, m_addr, m_tag, m_data);
        end
      end
      nchk++;
      if (bus_a.protocol_err !== m_err) begin nfail++; $display("FAIL random protocol_err @%0d: got %b want %b", i, bus_a.protocol_err, m_err); end
      tick();
    end
    drive_a(mk(0, '0, '0, '0, 0, 1));
    tick();
  endtask

  task automatic test_beats1();
    bit fr, exp_rdy;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      fr = (i < 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus_b.mem_rsp_valid = (i < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus_b.mem_rsp_data  = rnd512();
      bus_b.mem_rsp_addr  = AW'($urandom);
      bus_b.mem_rsp_tag   = TW'($urandom);
      bus_b.mem_rsp_last  = 1'b1;
      bus_b.fill_ready    = fr;
      @(negedge clk);
      exp_rdy = !b_pv || fr;
      nchk++;
      if (bus_b.mem_rsp_ready !== exp_rdy) begin nfail++; $display("FAIL beats1 ready @%0d: got %b want %b", i, bus_b.mem_rsp_ready, exp_rdy); end
      nchk++;
      if (bus_b.fill_valid !== b_pv) begin nfail++; $display("FAIL beats1 fill_valid @%0d: got %b want %b", i, bus_b.fill_valid, b_pv); end
      if (b_pv) begin
        nchk++;
        if ({bus_b.fill_addr, bus_b.fill_tag, bus_b.fill_data} !== {b_addr, b_tag, b_data}) begin
          nfail++; $display("FAIL beats1 line @%0d: got %h/%h/%h want %h/%h/%h", i,
                            bus_b.fill_addr, bus_b.fill_tag, bus_b.fill_data, b_addr, b_tag, b_data);
        end
      end
      if (i >= 1 && i < 20) begin
        nchk++;
        if (bus_b.fill_valid !== 1'b1) begin nfail++; $display("FAIL beats1 one-per-cycle @%0d: got %b want 1", i, bus_b.fill_valid); end
      end
      nchk++;
      if (bus_b.protocol_err !== 1'b0) begin nfail++; $display("FAIL beats1 protocol_err @%0d: got %b want 0", i, bus_b.protocol_err); end
      tick();
    end
    bus_b.mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.mem_rsp_valid = 1'b0; bus_a.mem_rsp_data = '0; bus_a.mem_rsp_addr = '0;
    bus_a.mem_rsp_tag = '0; bus_a.mem_rsp_last = 1'b0; bus_a.fill_ready = 1'b0;
    bus_b.mem_rsp_valid = 1'b0; bus_b.mem_rsp_data = '0; bus_b.mem_rsp_addr = '0;
    bus_b.mem_rsp_tag = '0; bus_b.mem_rsp_last = 1'b0; bus_b.fill_ready = 1'b0;
    model_clear();
    test_reset();
    test_assembly();
    test_backpressure();
    test_back_to_back();
    test_protocol_err();
    test_reset_midline();
    test_random();
    test_beats1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/vx_fill_assembler.md
Name: vx_fill_assembler

Overview:
- Sits between the bank's memory-response interface and the data-store write port of the cache bank.
- Collects narrow memory-response beats into one full cache line.
- Presents the assembled line, line address and MSHR tag as a single fill request through a valid/ready handshake.
- The fill request drives the data store's fill, fill_data and addr inputs.

Parameters:
- CACHE_LINE_SIZE, 64, line size in bytes.
- MEM_DATA_WIDTH, 128, memory-response beat width in bits. Must divide CACHE_LINE_SIZE*8.
- LINE_ADDR_WIDTH, 26, width of the line address.
- TAG_WIDTH, 8, MSHR/request tag width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_rsp_valid  in  1  beat valid
- mem_rsp_ready  out  1  beat accepted when valid&&ready
- mem_rsp_data  in  MEM_DATA_WIDTH  beat payload
- mem_rsp_addr  in  LINE_ADDR_WIDTH  line address; sampled on the first beat only
- mem_rsp_tag  in  TAG_WIDTH  tag; sampled on the first beat only
- mem_rsp_last  in  1  source's end-of-line marker; checked, never trusted
- fill_valid  out  1  assembled line available
- fill_ready  in  1  bank accepts fill (bank not stalled)
- fill_addr  out  LINE_ADDR_WIDTH  line address of the fill
- fill_tag  out  TAG_WIDTH  tag of the fill
- fill_data  out  CACHE_LINE_SIZE*8  assembled line
- protocol_err  out  1  sticky flag: mem_rsp_last mismatch

Behaviour:
- BEATS = CACHE_LINE_SIZE*8/MEM_DATA_WIDTH. The beat counter is clog2(BEATS) bits wide, with a minimum of 1.
- States:
  - COLLECT: accumulating beats.
  - PRESENT: full line held, fill_valid=1.
- Reset values (asynchronous): state=COLLECT, beat counter=0, fill_valid=0, protocol_err=0.
  - The data, address and tag registers have no reset; their value is don't-care while fill_valid=0.
- COLLECT:
  - mem_rsp_ready=1.
  - Each accepted beat k writes fill_data[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH]. Beat 0 is in the least-significant bits.
  - Beat 0 also captures addr and tag.
  - The counter increments per beat.
  - On acceptance of beat BEATS-1: counter wraps to 0, state goes to PRESENT.
  - fill_valid rises the cycle after the last beat handshake. Latency from last beat to fill_valid is 1 cycle.
- PRESENT:
  - fill_valid=1. fill_data, fill_addr and fill_tag are held stable until the handshake.
  - mem_rsp_ready = fill_ready (combinational), which allows overlap.
  - Handshake with no beat that cycle: state goes to COLLECT.
  - Simultaneous fill handshake and beat acceptance: the beat is written as beat 0 of the next line and the counter goes to 1.
    - If BEATS==1, the line is immediately complete and the state stays PRESENT with new contents.
- fill_valid must not drop without a handshake. fill_valid never depends combinationally on fill_ready.
- protocol_err is set and sticky until reset when either:
  - mem_rsp_last=1 on an accepted beat whose index is not BEATS-1, or
  - mem_rsp_last=0 on an accepted beat whose index is BEATS-1.
- The line still completes by count; no beat is dropped or inserted.
- Reset mid-line: the partial line is discarded and the counter is cleared. Any pending fill is discarded (fill_valid=0 immediately).
- Throughput: one beat per cycle sustained, including across line boundaries when fill_ready=1.

Decomposition:
- Shared cache package/header contents:
  - BEATS calculation
  - beat-select width via the codebase UP/CLOG2 macros
  - fill request struct {addr, tag, data}, reused by the bank's fill mux
- Optional sub-module vx_fill_beat_ctr: beat counter, wrap and last-mismatch detection. Everything else stays in the top module.

Test Plan:
- Line assembly (BEATS=4, 128-bit beats): beats 0x11.., 0x22.., 0x33.., 0x44.. with addr=0x123, tag=5, last on beat 3, fill_ready=1.
  - fill_valid=1 exactly one cycle after beat 3.
  - fill_data = {0x44..,0x33..,0x22..,0x11..}, fill_addr=0x123, fill_tag=5.
  - Handshake in that cycle; protocol_err=0.
- Backpressure: fill_ready=0 for 5 cycles after assembly.
  - fill_valid stays 1 with unchanged data; mem_rsp_ready=0.
  - A pending mem_rsp_valid beat is not consumed until fill_ready=1.
- Back-to-back lines: 8 consecutive beats, fill_ready=1.
  - Beat 4 is accepted in the same cycle as the first fill handshake.
  - Two fills with tags 5 and 6; no bubble cycle on mem_rsp_ready.
- Protocol error:
  - mem_rsp_last=1 on beat 1: protocol_err=1 the next cycle; the fill still appears after beat 3; the flag stays 1 through later clean lines.
  - Separately, last=0 on beat 3 also sets the flag.
- Reset mid-line: assert reset after beat 2 of line A, then send a full line B.
  - fill_valid=0 during reset; exactly one fill (line B data/addr) results.
  - No beats of A appear in the fill data.
- BEATS=1 configuration (MEM_DATA_WIDTH=CACHE_LINE_SIZE*8): continuous beats with fill_ready=1.
  - One fill per cycle; each beat is presented the cycle after acceptance.
